// File: rtl/core_config_loader_if.sv
// Configuration loader bus bundle.
// Carries the incoming configuration byte stream and the instruction-memory
// write port, plus the load status levels.
//   rx_valid / rx_data       : byte stream into the loader
//   imem_we/addr/wdata       : one-cycle word writes into instruction memory
//   config_done/config_error : load status back to the power/reset FSM
// Modports: master = stream source / status sink, slave = the loader.
interface core_config_loader_if #(
   parameter int ADDR_W = 10
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              config_done;
   logic              config_error;

   modport master (
      output rx_valid, rx_data,
      input  imem_we, imem_addr, imem_wdata, config_done, config_error
   );

   modport slave (
      input  rx_valid, rx_data,
      output imem_we, imem_addr, imem_wdata, config_done, config_error
   );
endinterface

// File: rtl/core_config_loader.sv
// Core configuration loader.
// While core_reset_n is low, parses a byte stream of the form
// {count[7:0], count[15:8], count x 4-byte little-endian words} and writes
// each word into instruction memory at consecutive word addresses.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   core_reset_n : low requests a configuration load, high aborts/acknowledges
//   bus          : stream in, imem write port and status out (slave modport)
//
// state  | meaning
// IDLE   | waiting for core_reset_n low, outputs low
// LEN_LO | waiting for word count low byte
// LEN_HI | waiting for word count high byte, range-checks the count
// DATA   | assembling words and writing them
// DONE   | load complete, config_done high until core_reset_n high
// ERR    | count exceeded DEPTH, config_error high until core_reset_n high
module core_config_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input logic                 clk,
   input logic                 rst_n,
   input logic                 core_reset_n,
   core_config_loader_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t            state_q, state_d;
   logic [15:0]       count_q;
   logic [15:0]       word_idx_q;
   logic [1:0]        byte_idx_q;
   logic [23:0]       asm_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [15:0]       full_count;
   logic              byte_take;

   assign full_count = {bus.rx_data, count_q[7:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (!core_reset_n) state_d = LEN_LO;
         LEN_LO: begin
            if (core_reset_n)       state_d = IDLE;
            else if (bus.rx_valid)  state_d = LEN_HI;
         end
         LEN_HI: begin
            if (core_reset_n)                     state_d = IDLE;
            else if (bus.rx_valid) begin
               if (full_count == 16'd0)           state_d = DONE;
               else if ({1'b0, full_count} > DEPTH_L) state_d = ERR;
               else                               state_d = DATA;
            end
         end
         // Leave DATA on the edge that retires the final write strobe;
         // word_idx_q already points one past the last word written.
         DATA: begin
            if (core_reset_n)                         state_d = IDLE;
            else if (we_q && (word_idx_q == count_q)) state_d = DONE;
         end
         DONE:   if (core_reset_n) state_d = IDLE;
         ERR:    if (core_reset_n) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A byte is consumed only while staying in DATA, so an abort or the
   // final-write exit discards it along with any partial word.
   assign byte_take = (state_q == DATA) && (state_d == DATA) && bus.rx_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         asm_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         if (state_q == LEN_LO && !core_reset_n && bus.rx_valid)
            count_q[7:0] <= bus.rx_data;
         if (state_q == LEN_HI && !core_reset_n && bus.rx_valid) begin
            count_q[15:8] <= bus.rx_data;
            word_idx_q    <= '0;
            byte_idx_q    <= '0;
            asm_q         <= '0;
         end
         if (byte_take) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
               2'd0: asm_q[7:0]   <= bus.rx_data;
               2'd1: asm_q[15:8]  <= bus.rx_data;
               2'd2: asm_q[23:16] <= bus.rx_data;
               default: begin
                  we_q       <= 1'b1;
                  addr_q     <= word_idx_q[ADDR_W-1:0];
                  wdata_q    <= {bus.rx_data, asm_q};
                  word_idx_q <= word_idx_q + 16'd1;
               end
            endcase
         end
      end
   end

   assign bus.imem_we      = we_q;
   assign bus.imem_addr    = addr_q;
   assign bus.imem_wdata   = wdata_q;
   assign bus.config_done  = (state_q == DONE);
   assign bus.config_error = (state_q == ERR);

endmodule
